mmio_timer: RTL
===============

# mmio_timer

Memory-mapped programmable down-counter timer that acts as a responder on the CPU data-memory bus (ce/we/addr/sel/data), alongside the data RAM in the minimal SOPC. It decodes a 32-byte window, supports byte-enabled register writes and same-cycle reads, and raises a level interrupt routed to one bit of the CPU's `int_i` vector.

## Interface
Parameters:
- `BASE_ADDR`, 32'h2000_0000, window base; decode on `addr[31:5] == BASE_ADDR[31:5]`.
- `CNT_W`, 32, counter/LOAD width (≤32; narrower registers read zero-extended).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  bus access valid.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  32  byte address; `addr[4:2]` selects register, `addr[1:0]` ignored.
- `sel`  in  4  byte enables; `sel[i]` gates `data_i[8i+7:8i]` (sel[3] = bits 31:24).
- `data_i`  in  32  write data.
- `data_o`  out  32  read data.
- `hit_o`  out  1  combinational: `ce` and address in window.
- `int_o`  out  1  interrupt request, level, active-high.

## Operation
- Registers (offset): CTRL 0x00 = {EN bit0, AUTO bit1, IE bit2}; LOAD 0x04; COUNT 0x08 (read-only); STATUS 0x0C = {PEND bit0}, write-1-to-clear; 0x10 PRESCALE (see Configuration); 0x14–0x1C reserved, read 0, writes ignored.
- Write: on rising edge when `ce & we & hit`, each enabled byte updated; unused CTRL/STATUS bits read 0.
- Writing any byte of LOAD also copies the resulting full LOAD value into COUNT that edge.
- Tick: one per cycle (or per prescaler terminal count). While EN=1, on each tick: COUNT≠0 → COUNT−1; COUNT=0 → expiry.
- Expiry: PEND←1; AUTO=1 → COUNT←LOAD, EN stays 1; AUTO=0 → COUNT stays 0, EN←0 (one-shot).
- Period with AUTO=1 is LOAD+1 ticks; LOAD=0 expires every tick.
- `int_o = PEND & IE`.
- EN=0 freezes COUNT and prescaler; setting EN does not reload COUNT.

## Timing
- Reset: CTRL, LOAD, COUNT, STATUS, PRESCALE, prescaler counter all 0; `int_o`=0; `data_o`=0.
- Read: combinational, zero wait states; `data_o` valid same cycle when `ce & ~we & hit`, else 32'h0.
- Write visible on read the cycle after the write edge.
- Expiry decided from COUNT value at the edge; PEND and `int_o` assert on the following cycle (1-cycle latency from COUNT=0 observed).
- Simultaneous expiry and STATUS W1C same edge: set wins, PEND=1.
- Simultaneous LOAD write and decrement/reload same edge: bus write wins, COUNT←new LOAD.
- Simultaneous CTRL write clearing EN and expiry: expiry still sets PEND; EN=0 afterwards; AUTO reload still applied.
- `rst` asserted mid-count: all state clears immediately, independent of `clk`; deassertion takes effect at next edge.
- `ce=0`: no state change from bus; counter keeps running.

## Configuration
- `MMIO_TIMER_PRESCALER_EN` defined: PRESCALE register (16 bits, offset 0x10, byte-writable) present; internal counter counts 0..PRESCALE and issues one tick at terminal count, then wraps to 0; PRESCALE=0 → tick every cycle; writing PRESCALE resets the prescaler counter to 0.
- Not defined: no PRESCALE register (0x10 reads 0, writes ignored); tick every cycle while EN=1.

## Test plan
- Reset: hold `rst`=0 mid-run with EN=1, COUNT=5 → all registers read 0, `int_o`=0 immediately.
- One-shot: write LOAD=3, CTRL=0x5 → COUNT reads 3,2,1,0 on successive cycles; PEND=1 and `int_o`=1 the cycle after COUNT=0; CTRL reads 0x4; COUNT holds 0.
- Auto-reload: LOAD=2, CTRL=0x3 → PEND rises every 3 cycles; `int_o` stays 0 (IE=0); write STATUS=1 clears PEND next cycle.
- Byte enables: write LOAD 32'hAABBCCDD with sel=4'b0011 after LOAD=0 → LOAD and COUNT read 32'h0000CCDD; read at BASE+0x18 → 0; read with addr outside window → `data_o`=0, `hit_o`=0.
- Collision: STATUS W1C on same edge as expiry → PEND reads 1; LOAD write on same edge as decrement → COUNT equals written value.
- With `MMIO_TIMER_PRESCALER_EN`: PRESCALE=3, LOAD=1, CTRL=0x3 → COUNT changes every 4 cycles, PEND period 8 cycles.

Source files
------------

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: data-memory bus seen by the mmio_timer responder.
// The CPU side drives the access; the timer returns read data and the
// combinational window-hit indication.
interface mmio_timer_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        hit_o;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o, hit_o
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o, hit_o
  );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped programmable down-counter with level interrupt.
// Register map (byte offsets in a 32-byte window):
//   0x00 CTRL   {IE, AUTO, EN}
//   0x04 LOAD   writing any byte also copies the new LOAD into COUNT
//   0x08 COUNT  read-only
//   0x0C STATUS {PEND}, write-1-to-clear
//   0x10 PRESCALE (16 bits) when MMIO_TIMER_PRESCALER_EN is defined
// Optional feature macro: MMIO_TIMER_PRESCALER_EN. When undefined, the
// timer ticks every cycle while EN=1 and offset 0x10 reads as zero.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  mmio_timer_if.slave  bus,
  output logic         int_o
);

  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;

  logic             hit;
  logic [2:0]       reg_idx;
  logic             wr_ctrl, wr_load, wr_stat;
  logic [31:0]      load_merged;
  logic [CNT_W-1:0] load_wr_val;
  logic             tick;
  logic             expire;
  logic             unused_ok;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign hit       = bus.ce & (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign bus.hit_o = hit;
  assign reg_idx   = bus.addr[4:2];
  assign unused_ok = &{1'b0, bus.addr[1:0]};

  assign wr_ctrl = hit & bus.we & (reg_idx == 3'd0) & bus.sel[0];
  assign wr_load = hit & bus.we & (reg_idx == 3'd1) & (|bus.sel);
  assign wr_stat = hit & bus.we & (reg_idx == 3'd3) & bus.sel[0];

  assign load_merged = merge_bytes(32'(load_q), bus.data_i, bus.sel);
  assign load_wr_val = CNT_W'(load_merged);

`ifdef MMIO_TIMER_PRESCALER_EN
  logic [15:0] presc_q, presc_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        wr_presc;
  logic [31:0] presc_merged;

  assign wr_presc     = hit & bus.we & (reg_idx == 3'd4) & (|bus.sel[1:0]);
  assign presc_merged = merge_bytes({16'h0, presc_q}, bus.data_i, bus.sel);
  assign tick         = ctrl_q[0] & (pcnt_q == presc_q);

  // Prescaler next state: wraps at PRESCALE, frozen while EN=0, restarts on write.
  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (ctrl_q[0]) begin
      pcnt_d = (pcnt_q == presc_q) ? 16'h0 : pcnt_q + 16'h1;
    end
    if (wr_presc) begin
      presc_d = presc_merged[15:0];
      pcnt_d  = 16'h0;
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= 16'h0;
      pcnt_q  <= 16'h0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = ctrl_q[0];
`endif

  assign expire = tick & (count_q == '0);

  // Timer next state; bus writes are applied last so they win any collision.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    pend_d  = pend_q;

    if (tick) begin
      if (count_q == '0) begin
        if (ctrl_q[1]) count_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

    if (wr_stat && bus.data_i[0]) pend_d = 1'b0;
    // Expiry set has priority over a same-edge clear.
    if (expire) pend_d = 1'b1;

    if (wr_ctrl) ctrl_d = bus.data_i[2:0];
    if (wr_load) begin
      load_d  = load_wr_val;
      count_d = load_wr_val;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= 3'b0;
      load_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  assign int_o = pend_q & ctrl_q[2];

  // Zero-wait-state read mux; idle bus returns zero.
  always_comb begin
    bus.data_o = 32'h0;
    if (hit && !bus.we) begin
      unique case (reg_idx)
        3'd0: bus.data_o = {29'h0, ctrl_q};
        3'd1: bus.data_o = 32'(load_q);
        3'd2: bus.data_o = 32'(count_q);
        3'd3: bus.data_o = {31'h0, pend_q};
`ifdef MMIO_TIMER_PRESCALER_EN
        3'd4: bus.data_o = {16'h0, presc_q};
`endif
        default: bus.data_o = 32'h0;
      endcase
    end
  end

endmodule
